// File: rtl/config_stream_loader.sv
// Word-serial configuration loader: assembles a frame from a valid/ready
// word stream and commits it atomically to the config_out shadow register.
module config_stream_loader #(
    parameter int CONFIG_WIDTH = 112,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_valid,
    output logic                    busy,
    output logic                    load_done
);

    localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int SHIFT_W   = NUM_WORDS * WORD_WIDTH;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [SHIFT_W-1:0] shift_reg;
    logic [SHIFT_W-1:0] shift_next;
    logic               xfer;

    // New words enter at the MSB end so the first word ends up at bit 0.
    generate
        if (NUM_WORDS == 1) begin : g_single
            assign shift_next = data_in;
        end else begin : g_multi
            assign shift_next = {data_in, shift_reg[SHIFT_W-1:WORD_WIDTH]};
        end
    endgenerate

    assign xfer = data_valid && data_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            shift_reg    <= '0;
            config_out   <= '0;
            config_valid <= 1'b0;
            busy         <= 1'b0;
            load_done    <= 1'b0;
            data_ready   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        count      <= '0;
                        data_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    // A restart drops the partial frame and any word offered with it.
                    if (start) begin
                        count <= '0;
                    end else if (xfer) begin
                        shift_reg <= shift_next;
                        count     <= count + 1'b1;
                        if (count == LAST) begin
                            state      <= COMMIT;
                            data_ready <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    config_out   <= shift_reg[CONFIG_WIDTH-1:0];
                    config_valid <= 1'b1;
                    load_done    <= 1'b1;
                    count        <= '0;
                    if (start) begin
                        state      <= LOAD;
                        data_ready <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        data_ready <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    count      <= '0;
                    data_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_stream_loader.sv
// Bench for config_stream_loader: directed and random frames on an 8-bit
// and a 5-bit word instance, checked against a queue-based frame model.
module tb_config_stream_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset;
    logic         s0, v0, s1, v1;
    logic [7:0]   d0;
    logic [4:0]   d1;
    logic         r0, cv0, b0, ld0;
    logic         r1, cv1, b1, ld1;
    logic [111:0] cfg0, cfg1;

    config_stream_loader #(.CONFIG_WIDTH(112), .WORD_WIDTH(8)) u0 (
        .clock(clock), .reset(reset), .start(s0),
        .data_in(d0), .data_valid(v0), .data_ready(r0),
        .config_out(cfg0), .config_valid(cv0),
        .busy(b0), .load_done(ld0)
    );

    config_stream_loader #(.CONFIG_WIDTH(112), .WORD_WIDTH(5)) u1 (
        .clock(clock), .reset(reset), .start(s1),
        .data_in(d1), .data_valid(v1), .data_ready(r1),
        .config_out(cfg1), .config_valid(cv1),
        .busy(b1), .load_done(ld1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int done0  = 0;

    // Frame model: a frame is the list of accepted words; the committed
    // configuration is those words laid out from bit 0 upwards.
    bit           m_load[2];
    bit           m_commit[2];
    bit           m_valid[2];
    bit           m_done[2];
    logic [111:0] m_cfg[2];
    int           words[2][$];
    int           nw[2] = '{14, 23};
    int           ww[2] = '{8, 5};

    function automatic logic [111:0] pack(input int id);
        logic [111:0] r;
        r = '0;
        for (int k = 0; k < words[id].size(); k++)
            for (int b = 0; b < ww[id]; b++)
                if (k * ww[id] + b < 112)
                    r[k * ww[id] + b] = 1'((words[id][k] >> b) & 1);
        return r;
    endfunction

    task automatic model_step(input int id, input bit s, input bit v, input int d);
        if (reset) begin
            m_load[id] = 0; m_commit[id] = 0; m_valid[id] = 0;
            m_done[id] = 0; m_cfg[id] = '0; words[id].delete();
            return;
        end
        m_done[id] = 0;
        if (m_commit[id]) begin
            m_cfg[id] = pack(id);
            m_valid[id] = 1; m_done[id] = 1; m_commit[id] = 0;
            words[id].delete();
            m_load[id] = s;
        end else if (!m_load[id]) begin
            if (s) begin m_load[id] = 1; words[id].delete(); end
        end else if (s) begin
            words[id].delete();
        end else if (v) begin
            words[id].push_back(d);
            if (words[id].size() == nw[id]) begin
                m_load[id] = 0; m_commit[id] = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ready0", 112'(r0), 112'(m_load[0]));
        chk("busy0", 112'(b0), 112'(m_load[0] | m_commit[0]));
        chk("cvalid0", 112'(cv0), 112'(m_valid[0]));
        chk("done0", 112'(ld0), 112'(m_done[0]));
        chk("cfg0", cfg0, m_cfg[0]);
        chk("ready1", 112'(r1), 112'(m_load[1]));
        chk("busy1", 112'(b1), 112'(m_load[1] | m_commit[1]));
        chk("cvalid1", 112'(cv1), 112'(m_valid[1]));
        chk("done1", 112'(ld1), 112'(m_done[1]));
        chk("cfg1", cfg1, m_cfg[1]);
    endtask

    task automatic step();
        @(posedge clock);
        model_step(0, s0, v0, int'(d0));
        model_step(1, s1, v1, int'(d1));
        #1;
        check_all();
        if (ld0) done0++;
    endtask

    task automatic cyc0(input bit s, input bit v, input int d);
        s0 = s; v0 = v; d0 = 8'(d);
        s1 = 0; v1 = 0; d1 = '0;
        step();
    endtask

    task automatic cyc1(input bit s, input bit v, input int d);
        s1 = s; v1 = v; d1 = 5'(d);
        s0 = 0; v0 = 0; d0 = '0;
        step();
    endtask

    initial begin
        logic [111:0] e;
        int c;
        int k;
        reset = 1; s0 = 0; v0 = 0; d0 = '0; s1 = 0; v1 = 0; d1 = '0;
        step();
        step();
        reset = 0;
        chk("reset_cfg", cfg0, '0);
        chk("reset_ready", 112'(r0), '0);

        // Directed frame 0x00..0x0D, one word per cycle
        done0 = 0;
        cyc0(1, 0, 0);
        for (int i = 0; i < 14; i++) cyc0(0, 1, i);
        for (int i = 0; i < 3; i++) cyc0(0, 0, 0);
        chk("t1_low", 112'(cfg0[7:0]), 112'(8'h00));
        chk("t1_high", 112'(cfg0[111:104]), 112'(8'h0D));
        chk("t1_pulses", 112'(done0), 112'(1));
        chk("t1_busy", 112'(b0), '0);

        // Words offered in IDLE are refused, then a 1010 valid pattern
        for (int i = 0; i < 3; i++) cyc0(0, 1, 8'hEE);
        cyc0(1, 0, 0);
        k = 0;
        while (k < 14) begin
            cyc0(0, 1, k); k++;
            cyc0(0, 0, 8'hAA);
        end
        for (int i = 0; i < 2; i++) cyc0(0, 0, 0);
        chk("t2_high", 112'(cfg0[111:104]), 112'(8'h0D));

        // Frame A, aborted partial frame, then frame B
        cyc0(1, 0, 0);
        for (int i = 0; i < 14; i++) cyc0(0, 1, 8'hFF);
        for (int i = 0; i < 2; i++) cyc0(0, 0, 0);
        chk("t3_ones", cfg0, {112{1'b1}});
        done0 = 0;
        cyc0(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc0(0, 1, 8'h00);
        cyc0(1, 1, 8'h33);
        for (int i = 0; i < 13; i++) cyc0(0, 1, 8'h5A);
        chk("t3_hold", cfg0, {112{1'b1}});
        cyc0(0, 1, 8'h5A);
        for (int i = 0; i < 2; i++) cyc0(0, 0, 0);
        chk("t3_5a", cfg0, {14{8'h5A}});
        chk("t3_pulses", 112'(done0), 112'(1));

        // Start in the commit cycle
        cyc0(1, 0, 0);
        for (int i = 0; i < 14; i++) cyc0(0, 1, $urandom);
        cyc0(1, 0, 0);
        chk("t6_done", 112'(ld0), 112'(1));
        chk("t6_ready", 112'(r0), 112'(1));
        for (int i = 0; i < 14; i++) cyc0(0, 1, $urandom);
        for (int i = 0; i < 2; i++) cyc0(0, 0, 0);

        // Random frames with random valid gaps and occasional restarts
        for (int f = 0; f < 4; f++) begin
            cyc0(1, 0, 0);
            c = 0;
            while (!m_commit[0] && c < 300) begin
                cyc0($urandom_range(39) == 0, 1'($urandom), $urandom);
                c++;
            end
            cyc0(0, 0, 0);
            chk("rand0_done", 112'(ld0), 112'(1));
        end

        // Reset after word 13 of 14
        cyc0(1, 0, 0);
        for (int i = 0; i < 13; i++) cyc0(0, 1, i + 1);
        s0 = 0; v0 = 0; reset = 1;
        step();
        reset = 0;
        chk("t4_cfg", cfg0, '0);
        chk("t4_cvalid", 112'(cv0), '0);
        chk("t4_busy", 112'(b0), '0);
        cyc0(0, 1, 14);
        chk("t4_ready", 112'(r0), '0);
        for (int i = 0; i < 2; i++) cyc0(0, 0, 0);
        chk("t4_after", 112'(cv0), '0);

        // 5-bit words: top 3 bits of the last word are dropped
        cyc1(1, 0, 0);
        for (int i = 0; i < 22; i++) cyc1(0, 1, 0);
        cyc1(0, 1, 5'h1F);
        cyc1(0, 0, 0);
        e = '0;
        e[111:110] = 2'b11;
        chk("t5_top", 112'(cfg1[111:110]), 112'(2'b11));
        chk("t5_cfg", cfg1, e);
        for (int f = 0; f < 3; f++) begin
            cyc1(1, 0, 0);
            c = 0;
            while (!m_commit[1] && c < 300) begin
                cyc1($urandom_range(49) == 0, 1'($urandom), $urandom);
                c++;
            end
            cyc1(0, 0, 0);
            chk("rand1_done", 112'(ld1), 112'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
